matrix_snapshot_serializer: RTL
===============================

Name: matrix_snapshot_serializer

Overview:
- Downstream of the 6x6 normal-equation accumulator (Matrix stage) in the RGB-D VO pipeline.
- On the accumulator's frame-end strobe, captures the 21 lower-triangle matrix words and 6 vector words into a snapshot bank.
- Streams the 27 words out one per valid/ready handshake to the pose solver.
- Decouples solver timing from the pixel stream, so the accumulators can restart on the next frame while the solver is still reading.

Parameters:
DATA_BW, MATRIX_BW (64), width of every matrix/vector word
NUM_WORDS, MAT_WORDS (27), words per snapshot (21 matrix + 6 vector)
IDX_BW, MAT_IDX_BW (5), width of word index output

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_end  in  1  one-cycle strobe; all i_Mat_*/i_Vec_* words are final in this cycle
i_Mat_00..i_Mat_55  in  DATA_BW each  21 lower-triangle words (00,10,20,30,40,50,11,21,31,41,51,22,32,42,52,33,43,53,44,54,55)
i_Vec_0..i_Vec_5  in  DATA_BW each  right-hand-side vector words
o_valid  out  1  output word valid
i_ready  in  1  consumer accepts word when o_valid && i_ready
o_data  out  DATA_BW  current word
o_idx  out  IDX_BW  index of current word, 0..26
o_last  out  1  high with word 26
o_busy  out  1  snapshot held, not fully drained
o_drop  out  1  one-cycle pulse: frame_end ignored because bank busy

Behaviour:
- Reset (async assert, sync deassert): state IDLE, o_valid=0, o_data=0, o_idx=0, o_last=0, o_busy=0, o_drop=0, snapshot bank cleared.
- FSM has two states: IDLE and SEND.
- IDLE, i_frame_end=1:
  - capture all 27 inputs on that edge
  - next cycle: state SEND, o_valid=1, o_idx=0, o_busy=1
  - capture-to-first-word latency is 1 cycle
- SEND:
  - Word order is index 0..20 = matrix words in the order listed above, 21..26 = Vec_0..Vec_5.
  - o_data = bank[o_idx], driven from registers (no combinational path from i_ready to o_data).
  - o_valid && !i_ready: o_data, o_idx and o_last hold stable.
  - Handshake on idx<26: idx increments next cycle.
  - Handshake on idx=26 (o_last=1): next cycle IDLE, o_valid=0, o_busy=0, idx=0.
  - Throughput is 1 word/cycle with i_ready held high, so a full snapshot drains in 27 cycles.
- i_frame_end in SEND, except in the final-handshake cycle:
  - strobe ignored, bank unchanged
  - o_drop=1 in the following cycle for exactly one cycle
- i_frame_end in the same cycle as the idx=26 handshake:
  - accepted: bank recaptured
  - next cycle SEND with idx=0, o_valid stays 1 (no bubble), o_drop=0
- Reset mid-SEND: immediate return to reset values; the partial snapshot is discarded.
- Data is passed through bit-exact; no arithmetic and no sign handling (words are treated as opaque DATA_BW vectors).
- o_last = o_valid && (o_idx == NUM_WORDS-1).

Decomposition:
- RgbdVoConfigPk gains:
  - localparam MAT_WORDS = 27
  - localparam MAT_IDX_BW = 5
  - typedef enum logic {SER_IDLE, SER_SEND} ser_state_t
- The bank is a flat DATA_BW x 27 register array indexed by o_idx.
- No sub-module: the FSM, counter and bank sit in one module.

Test Plan:
- Load Mat_xy = 0x100+10x+y and Vec_k = 0x200+k, pulse i_frame_end, i_ready=1 -> o_valid rises the next cycle, 27 consecutive words 0x100,0x110,0x120,...,0x155,0x200..0x205 with o_idx 0..26, o_last only on 0x205, o_busy falls after that word.
- Same load, i_ready toggling 1,0,0,1 repeatedly -> no word skipped or duplicated, o_data/o_idx stable during every stall, 27 handshakes total.
- Second i_frame_end at idx=5 with all inputs changed to 0xFFFF... -> o_drop high for one cycle, remaining 22 words still come from the first snapshot.
- Second i_frame_end coincident with the idx=26 handshake, new data Vec_5=0xDEAD -> idx=0 on the next cycle with no gap in o_valid, second stream ends with 0xDEAD, o_drop never asserted.
- Assert i_rst_n=0 at idx=10 for 2 cycles -> o_valid=0, o_busy=0 immediately; after release, idle until a new frame_end, which then streams from idx 0.
- Hold i_ready=0 for 100 cycles after capture -> o_valid held with idx 0 and data 0x100 throughout, and inputs changing meanwhile do not alter the bank.

Source files
------------

// File: rtl/matrix_snapshot_serializer_pkg.sv
// Shared configuration for the matrix snapshot serializer.
// Holds the word width, word count and index width used by the
// serializer and its consumers, and the serializer FSM state type.
package matrix_snapshot_serializer_pkg;

  // Width of every normal-equation matrix/vector word.
  localparam int MATRIX_BW = 64;

  // Words per snapshot: 21 lower-triangle matrix words + 6 vector words.
  localparam int MAT_TRI_WORDS = 21;
  localparam int MAT_VEC_WORDS = 6;
  localparam int MAT_WORDS     = MAT_TRI_WORDS + MAT_VEC_WORDS;

  // Width of the word index presented alongside each streamed word.
  localparam int MAT_IDX_BW = 5;

  // Serializer FSM: waiting for a frame, or streaming a held snapshot.
  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

endpackage

// File: rtl/matrix_snapshot_serializer.sv
// matrix_snapshot_serializer
//
// Sits behind the 6x6 normal-equation accumulator. On the accumulator's
// frame-end strobe the 21 lower-triangle matrix words and the 6 vector
// words are captured into a snapshot bank, then streamed one word per
// valid/ready handshake to the pose solver. Because the bank is a private
// copy, the accumulators may restart on the next frame while the solver
// is still reading.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame_end           one-cycle strobe, all input words final this cycle
//   i_Mat_00 .. i_Mat_55  21 lower-triangle matrix words
//   i_Vec_0 .. i_Vec_5    6 right-hand-side vector words
//   o_valid / i_ready     output handshake
//   o_data, o_idx         current word and its index (0..26)
//   o_last                high with the final word (index 26)
//   o_busy                a snapshot is held and not yet fully drained
//   o_drop                one-cycle pulse: a frame_end was ignored
module matrix_snapshot_serializer
  import matrix_snapshot_serializer_pkg::*;
#(
  parameter int DATA_BW   = MATRIX_BW,
  parameter int NUM_WORDS = MAT_WORDS,
  parameter int IDX_BW    = MAT_IDX_BW
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_end,
  input  logic [DATA_BW-1:0] i_Mat_00,
  input  logic [DATA_BW-1:0] i_Mat_10,
  input  logic [DATA_BW-1:0] i_Mat_20,
  input  logic [DATA_BW-1:0] i_Mat_30,
  input  logic [DATA_BW-1:0] i_Mat_40,
  input  logic [DATA_BW-1:0] i_Mat_50,
  input  logic [DATA_BW-1:0] i_Mat_11,
  input  logic [DATA_BW-1:0] i_Mat_21,
  input  logic [DATA_BW-1:0] i_Mat_31,
  input  logic [DATA_BW-1:0] i_Mat_41,
  input  logic [DATA_BW-1:0] i_Mat_51,
  input  logic [DATA_BW-1:0] i_Mat_22,
  input  logic [DATA_BW-1:0] i_Mat_32,
  input  logic [DATA_BW-1:0] i_Mat_42,
  input  logic [DATA_BW-1:0] i_Mat_52,
  input  logic [DATA_BW-1:0] i_Mat_33,
  input  logic [DATA_BW-1:0] i_Mat_43,
  input  logic [DATA_BW-1:0] i_Mat_53,
  input  logic [DATA_BW-1:0] i_Mat_44,
  input  logic [DATA_BW-1:0] i_Mat_54,
  input  logic [DATA_BW-1:0] i_Mat_55,
  input  logic [DATA_BW-1:0] i_Vec_0,
  input  logic [DATA_BW-1:0] i_Vec_1,
  input  logic [DATA_BW-1:0] i_Vec_2,
  input  logic [DATA_BW-1:0] i_Vec_3,
  input  logic [DATA_BW-1:0] i_Vec_4,
  input  logic [DATA_BW-1:0] i_Vec_5,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_BW-1:0] o_data,
  output logic [IDX_BW-1:0]  o_idx,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_drop
);

  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_WORDS - 1);

  ser_state_t         state_q, state_d;
  logic [IDX_BW-1:0]  idx_q, idx_d;
  logic               drop_q, drop_d;
  logic               capture;
  logic               at_last;
  logic               handshake;
  logic [DATA_BW-1:0] in_words [NUM_WORDS];
  logic [DATA_BW-1:0] bank     [NUM_WORDS];

  // Flatten the input ports into stream order: matrix words column by
  // column down the lower triangle, then the six vector words.
  always_comb begin
    in_words[0]  = i_Mat_00;
    in_words[1]  = i_Mat_10;
    in_words[2]  = i_Mat_20;
    in_words[3]  = i_Mat_30;
    in_words[4]  = i_Mat_40;
    in_words[5]  = i_Mat_50;
    in_words[6]  = i_Mat_11;
    in_words[7]  = i_Mat_21;
    in_words[8]  = i_Mat_31;
    in_words[9]  = i_Mat_41;
    in_words[10] = i_Mat_51;
    in_words[11] = i_Mat_22;
    in_words[12] = i_Mat_32;
    in_words[13] = i_Mat_42;
    in_words[14] = i_Mat_52;
    in_words[15] = i_Mat_33;
    in_words[16] = i_Mat_43;
    in_words[17] = i_Mat_53;
    in_words[18] = i_Mat_44;
    in_words[19] = i_Mat_54;
    in_words[20] = i_Mat_55;
    in_words[21] = i_Vec_0;
    in_words[22] = i_Vec_1;
    in_words[23] = i_Vec_2;
    in_words[24] = i_Vec_3;
    in_words[25] = i_Vec_4;
    in_words[26] = i_Vec_5;
  end

  assign at_last   = (idx_q == LAST_IDX);
  assign handshake = (state_q == SER_SEND) && i_ready;

  // State, index and drop-pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic. A frame_end is taken when idle, or when it lands on
  // the cycle the final word is handed off, so back-to-back frames stream
  // without a bubble. Any other frame_end while sending is dropped and
  // flagged, leaving the held snapshot intact.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      SER_IDLE: begin
        idx_d = '0;
        if (i_frame_end) begin
          capture = 1'b1;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (handshake && at_last) begin
          idx_d = '0;
          if (i_frame_end) begin
            capture = 1'b1;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          if (handshake) begin
            idx_d = idx_q + IDX_BW'(1);
          end
          drop_d = i_frame_end;
        end
      end
      default: begin
        state_d = SER_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Snapshot bank: only written on an accepted frame_end, so input
  // changes while streaming never disturb the words being read out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= in_words[i];
      end
    end
  end

  // Outputs come purely from registers; i_ready only affects the next
  // cycle, so the word and index hold steady across a stall.
  assign o_valid = (state_q == SER_SEND);
  assign o_busy  = (state_q == SER_SEND);
  assign o_idx   = idx_q;
  assign o_last  = o_valid && at_last;
  assign o_drop  = drop_q;
  assign o_data  = o_valid ? bank[idx_q] : '0;

endmodule
